// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, glitch-filtered receiver, sticky errors.
// Define UART_PARITY_EN to add the per-frame parity bit (cfg_parity).
module uart_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;

  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign pop   = rd && !empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign push  = wr && (!full || pop);
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module uart_fifo_core #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [15:0]                 period,
  input  logic [1:0]                  cfg_parity,
  input  logic                        tx_wr,
  input  logic [DATA_W-1:0]           tx_wdata,
  output logic                        tx_full,
  output logic                        tx_idle,
  output logic                        txd,
  input  logic                        rxd,
  input  logic                        rx_rd,
  output logic [DATA_W-1:0]           rx_rdata,
  output logic                        rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  input  logic                        err_clear,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        par_err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif

  logic [15:0] per_eff;
  assign per_eff = (period < 16'd4) ? 16'd4 : period;

  logic                        tx_empty;
  logic                        tx_load;
  logic                        tx_end;
  logic                        tx_last_stop;
  logic [DATA_W-1:0]           tx_head;
  logic [DATA_W-1:0]           tx_sh;
  logic [2:0]                  tx_st;
  logic [2:0]                  tx_after;
  logic [15:0]                 tx_per;
  logic [15:0]                 tx_tick;
  logic [3:0]                  tx_bit;
  logic                        tx_stp;
  logic [$clog2(FIFO_DEPTH):0] unused_tx_level;

  logic              rx_meta;
  logic              rxs;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_end;
  logic              rx_half;
  logic              rx_smp;
  logic              rx_push;
  logic              rx_pbad;
  logic              fe_set;
  logic              ov_set;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] rx_sh;
  logic [2:0]        rx_st;
  logic [2:0]        rx_after;
  logic [15:0]       rx_per;
  logic [15:0]       rx_tick;
  logic [3:0]        rx_bit;

`ifdef UART_PARITY_EN
  logic       tx_pbit;
  logic       ps_set;
  logic [1:0] tx_pm;
  logic [1:0] rx_pm;

  assign tx_after = (^tx_pm) ? S_PAR : S_STOP;
  assign rx_after = (^rx_pm) ? S_PAR : S_STOP;
  // only reached with even (01) or odd (10) mode, so bit 1 selects odd
  assign ps_set = rx_st == S_PAR && rx_end &&
                  (^rx_sh ^ rxs ^ rx_pm[1]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_pbit <= 1'b0;
      tx_pm   <= 2'b00;
      rx_pm   <= 2'b00;
      rx_pbad <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (tx_load) begin
        tx_pm   <= cfg_parity;
        tx_pbit <= ^tx_head ^ cfg_parity[1];
      end
      if (rx_st == S_IDLE && !rxs) rx_pm <= cfg_parity;
      if (rx_st == S_START) rx_pbad <= 1'b0;
      if (ps_set) rx_pbad <= 1'b1;
      par_err <= ps_set | (par_err & ~err_clear);
    end
  end
`else
  logic unused_par;
  assign unused_par = ^cfg_parity;
  assign tx_after   = S_STOP;
  assign rx_after   = S_STOP;
  assign rx_pbad    = 1'b0;
  assign par_err    = 1'b0;
`endif

  uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (tx_wr),
    .wdata (tx_wdata),
    .rd    (tx_load),
    .head  (tx_head),
    .count (unused_tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_end       = tx_tick == tx_per - 16'd1;
  assign tx_last_stop = tx_stp == 1'(STOP_BITS - 1);
  // back-to-back frames: reload straight out of the last stop bit
  assign tx_load = !tx_empty &&
                   (tx_st == S_IDLE ||
                    (tx_st == S_STOP && tx_end && tx_last_stop));
  assign tx_idle = tx_st == S_IDLE && tx_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_st   <= S_IDLE;
      tx_per  <= 16'd4;
      tx_tick <= '0;
      tx_bit  <= '0;
      tx_stp  <= 1'b0;
      tx_sh   <= '0;
    end else if (tx_load) begin
      tx_st   <= S_START;
      tx_per  <= per_eff;
      tx_tick <= '0;
      tx_sh   <= tx_head;
    end else begin
      case (tx_st)
        S_START: begin
          if (tx_end) begin
            tx_st   <= S_DATA;
            tx_tick <= '0;
            tx_bit  <= '0;
          end else tx_tick <= tx_tick + 16'd1;
        end
        S_DATA: begin
          if (tx_end) begin
            tx_tick <= '0;
            tx_sh   <= tx_sh >> 1;
            tx_bit  <= tx_bit + 4'd1;
            if (tx_bit == 4'(DATA_W - 1)) begin
              tx_st  <= tx_after;
              tx_stp <= 1'b0;
            end
          end else tx_tick <= tx_tick + 16'd1;
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (tx_end) begin
            tx_st   <= S_STOP;
            tx_tick <= '0;
            tx_stp  <= 1'b0;
          end else tx_tick <= tx_tick + 16'd1;
        end
`endif
        S_STOP: begin
          if (tx_end) begin
            tx_tick <= '0;
            if (tx_last_stop) tx_st <= S_IDLE;
            else tx_stp <= tx_stp + 1'b1;
          end else tx_tick <= tx_tick + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    txd = 1'b1;
    case (tx_st)
      S_START: txd = 1'b0;
      S_DATA:  txd = tx_sh[0];
`ifdef UART_PARITY_EN
      S_PAR:   txd = tx_pbit;
`endif
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign rx_end  = rx_tick == rx_per - 16'd1;
  assign rx_half = rx_tick == (rx_per >> 1) - 16'd1;
  assign rx_smp  = rx_st == S_STOP && rx_end;
  assign fe_set  = rx_smp && !rxs;
  assign rx_push = rx_smp && rxs && !rx_pbad;
  assign ov_set  = rx_push && rx_full && !rx_rd;

  uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .wr    (rx_push),
    .wdata (rx_sh),
    .rd    (rx_rd),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_valid = !rx_empty;
  assign rx_rdata = rx_empty ? '0 : rx_head;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_st   <= S_IDLE;
      rx_per  <= 16'd4;
      rx_tick <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      case (rx_st)
        S_IDLE: begin
          if (!rxs) begin
            rx_st   <= S_START;
            rx_per  <= per_eff;
            rx_tick <= '0;
          end
        end
        S_START: begin
          if (rx_half) begin
            rx_tick <= '0;
            rx_bit  <= '0;
            rx_st   <= rxs ? S_IDLE : S_DATA;
          end else rx_tick <= rx_tick + 16'd1;
        end
        S_DATA: begin
          if (rx_end) begin
            rx_tick <= '0;
            rx_sh   <= {rxs, rx_sh[DATA_W-1:1]};
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit == 4'(DATA_W - 1)) rx_st <= rx_after;
          end else rx_tick <= rx_tick + 16'd1;
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (rx_end) begin
            rx_tick <= '0;
            rx_st   <= S_STOP;
          end else rx_tick <= rx_tick + 16'd1;
        end
`endif
        S_STOP: begin
          if (rx_end) begin
            rx_tick <= '0;
            rx_st   <= S_IDLE;
          end else rx_tick <= rx_tick + 16'd1;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set | (frame_err & ~err_clear);
      overrun   <= ov_set | (overrun & ~err_clear);
    end
  end
endmodule
